hazard_unit_pipe: RTL and testbench

- Parametrised hazard/forwarding controller for the 5-stage in-order RISC-V pipeline (IF/ID/EX/MEM/WB).
- Computes the EX operand forward selects.
- Detects load-use hazards and inserts a configurable number of bubbles through a stall counter FSM.
- Holds ID for one cycle when the regfile is not write-through; handles branch-flush priority over stalls.

---
 rtl/hazard_unit_pipe.sv | 165 ++++++++++++++++
 tb/tb_hazard_unit_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_pipe.sv
// Hazard and forwarding controller for the 5-stage in-order pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_unit_pipe #(
    parameter int REG_AW           = 5,
    parameter int LOAD_BUBBLES     = 1,
    parameter int RF_WRITE_THROUGH = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs1_addr_id_i,
    input  logic [REG_AW-1:0] rs2_addr_id_i,
    input  logic              rs1_use_id_i,
    input  logic              rs2_use_id_i,
    input  logic [REG_AW-1:0] rs1_addr_ex_i,
    input  logic [REG_AW-1:0] rs2_addr_ex_i,
    input  logic [REG_AW-1:0] rd_addr_ex_i,
    input  logic              rd_wren_ex_i,
    input  logic              is_load_ex_i,
    input  logic [REG_AW-1:0] rd_addr_mem_i,
    input  logic              rd_wren_mem_i,
    input  logic              is_load_mem_i,
    input  logic [REG_AW-1:0] rd_addr_wb_i,
    input  logic              rd_wren_wb_i,
    input  logic              is_load_wb_i,
    input  logic              br_taken_ex_i,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       perf_ld_stall_o,
    output logic [31:0]       perf_rf_stall_o,
    output logic [31:0]       perf_flush_o,
`endif
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              bubble_ex_o,
    output logic              flush_id_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {RUN, LD_STALL, RF_WAIT} state_t;

    localparam logic [2:0] LB_M1 = 3'(LOAD_BUBBLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ld_hazard, rf_hazard;
    logic       stall, bubble, flush, ld_cyc, rf_cyc;

    // A load in MEM never forwards: its data is not ready until WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] x);
        logic [1:0] s;
        s = 2'd0;
        if (x == '0)
            s = 2'd0;
        else if (rd_wren_mem_i && rd_addr_mem_i == x && !is_load_mem_i)
            s = 2'd1;
        else if (rd_wren_mem_i && rd_addr_mem_i == x)
            s = 2'd0;
        else if (rd_wren_wb_i && rd_addr_wb_i == x)
            s = is_load_wb_i ? 2'd3 : 2'd2;
        return s;
    endfunction

    // Hazard detection against the instruction sitting in ID
    always_comb begin
        ld_hazard = rd_wren_ex_i && is_load_ex_i && (rd_addr_ex_i != '0) &&
                    ((rs1_use_id_i && rs1_addr_id_i == rd_addr_ex_i) ||
                     (rs2_use_id_i && rs2_addr_id_i == rd_addr_ex_i));
        rf_hazard = (RF_WRITE_THROUGH == 0) && rd_wren_wb_i &&
                    (rd_addr_wb_i != '0) &&
                    ((rs1_use_id_i && rs1_addr_id_i == rd_addr_wb_i) ||
                     (rs2_use_id_i && rs2_addr_id_i == rd_addr_wb_i));
    end

    // Next-state and same-cycle stall/flush controls; branch wins everywhere
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        ld_cyc  = 1'b0;
        rf_cyc  = 1'b0;
        if (br_taken_ex_i) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = RUN;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ld_hazard) begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        ld_cyc  = 1'b1;
                        cnt_d   = LB_M1;
                        state_d = (LB_M1 != 3'd0) ? LD_STALL : RUN;
                    end else if (rf_hazard) begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        rf_cyc  = 1'b1;
                        state_d = RF_WAIT;
                    end
                end
                LD_STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    ld_cyc = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                RF_WAIT: state_d = RUN;
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State and bubble counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_ld_q, perf_rf_q, perf_fl_q;

    // Event counters, free-running with natural wrap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_ld_q <= '0;
            perf_rf_q <= '0;
            perf_fl_q <= '0;
        end else begin
            perf_ld_q <= perf_ld_q + {31'd0, ld_cyc};
            perf_rf_q <= perf_rf_q + {31'd0, rf_cyc};
            perf_fl_q <= perf_fl_q + {31'd0, flush};
        end
    end

    assign perf_ld_stall_o = perf_ld_q;
    assign perf_rf_stall_o = perf_rf_q;
    assign perf_flush_o    = perf_fl_q;
`endif

    assign fwd_a_sel_o = rst_i ? 2'd0 : fwd_sel(rs1_addr_ex_i);
    assign fwd_b_sel_o = rst_i ? 2'd0 : fwd_sel(rs2_addr_ex_i);
    assign stall_if_o  = !rst_i && stall;
    assign stall_id_o  = !rst_i && stall;
    assign bubble_ex_o = !rst_i && bubble;
    assign flush_id_o  = !rst_i && flush;
    assign busy_o      = !rst_i && (state_q != RUN);

endmodule

// File: tb/tb_hazard_unit_pipe.sv
// Directed bench for hazard_unit_pipe: u3 has 3 bubbles and no
// write-through, u1 has 1 bubble with write-through.
module tb_hazard_unit_pipe;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic use1, use2, wren_ex, ld_ex, wren_mem, ld_mem, wren_wb, ld_wb, br;

    logic [1:0] fa3, fb3, fa1, fb1;
    logic sif3, sid3, bx3, fl3, bz3;
    logic sif1, sid1, bx1, fl1, bz1;
`ifdef HAZARD_PERF_EN
    logic [31:0] pld3, prf3, pfl3, pld1, prf1, pfl1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit_pipe #(.REG_AW(5), .LOAD_BUBBLES(3), .RF_WRITE_THROUGH(0)) u3 (
        .clk_i(clk), .rst_i(rst),
        .rs1_addr_id_i(rs1_id), .rs2_addr_id_i(rs2_id),
        .rs1_use_id_i(use1), .rs2_use_id_i(use2),
        .rs1_addr_ex_i(rs1_ex), .rs2_addr_ex_i(rs2_ex),
        .rd_addr_ex_i(rd_ex), .rd_wren_ex_i(wren_ex), .is_load_ex_i(ld_ex),
        .rd_addr_mem_i(rd_mem), .rd_wren_mem_i(wren_mem), .is_load_mem_i(ld_mem),
        .rd_addr_wb_i(rd_wb), .rd_wren_wb_i(wren_wb), .is_load_wb_i(ld_wb),
        .br_taken_ex_i(br),
`ifdef HAZARD_PERF_EN
        .perf_ld_stall_o(pld3), .perf_rf_stall_o(prf3), .perf_flush_o(pfl3),
`endif
        .fwd_a_sel_o(fa3), .fwd_b_sel_o(fb3),
        .stall_if_o(sif3), .stall_id_o(sid3), .bubble_ex_o(bx3),
        .flush_id_o(fl3), .busy_o(bz3)
    );

    hazard_unit_pipe #(.REG_AW(5), .LOAD_BUBBLES(1), .RF_WRITE_THROUGH(1)) u1 (
        .clk_i(clk), .rst_i(rst),
        .rs1_addr_id_i(rs1_id), .rs2_addr_id_i(rs2_id),
        .rs1_use_id_i(use1), .rs2_use_id_i(use2),
        .rs1_addr_ex_i(rs1_ex), .rs2_addr_ex_i(rs2_ex),
        .rd_addr_ex_i(rd_ex), .rd_wren_ex_i(wren_ex), .is_load_ex_i(ld_ex),
        .rd_addr_mem_i(rd_mem), .rd_wren_mem_i(wren_mem), .is_load_mem_i(ld_mem),
        .rd_addr_wb_i(rd_wb), .rd_wren_wb_i(wren_wb), .is_load_wb_i(ld_wb),
        .br_taken_ex_i(br),
`ifdef HAZARD_PERF_EN
        .perf_ld_stall_o(pld1), .perf_rf_stall_o(prf1), .perf_flush_o(pfl1),
`endif
        .fwd_a_sel_o(fa1), .fwd_b_sel_o(fb1),
        .stall_if_o(sif1), .stall_id_o(sid1), .bubble_ex_o(bx1),
        .flush_id_o(fl1), .busy_o(bz1)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rdm, rdw;
        logic       wm, lm, ww, lw;
        logic [1:0] ea, eb;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic idle();
        rs1_id = 0; rs2_id = 0; use1 = 0; use2 = 0;
        rs1_ex = 0; rs2_ex = 0; rd_ex = 0; wren_ex = 0; ld_ex = 0;
        rd_mem = 0; wren_mem = 0; ld_mem = 0;
        rd_wb = 0; wren_wb = 0; ld_wb = 0; br = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // u3 controls: {stall_if, stall_id, bubble, flush, busy}
    task automatic ctl3(input string n, input logic [4:0] e);
        #1;
        chk({n, ".u3"}, {27'd0, sif3, sid3, bx3, fl3, bz3}, {27'd0, e});
    endtask

    task automatic ctl1(input string n, input logic [4:0] e);
        chk({n, ".u1"}, {27'd0, sif1, sid1, bx1, fl1, bz1}, {27'd0, e});
    endtask

    task automatic load_use();
        rd_ex = 7; wren_ex = 1; ld_ex = 1; rs2_id = 7; use2 = 1;
    endtask

    task automatic ex_bubble();
        rd_ex = 0; wren_ex = 0; ld_ex = 0;
    endtask

    vec_t tv[7];

    initial begin
        tv[0] = '{5'd5, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0};
        tv[1] = '{5'd5, 5'd0, 5'd6, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0};
        tv[2] = '{5'd5, 5'd0, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};
        tv[3] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        tv[4] = '{5'd3, 5'd4, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1};
        tv[5] = '{5'd3, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 2'd3};
        tv[6] = '{5'd3, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};

        idle();
        rst = 1;
        rs1_ex = 5; rd_mem = 5; wren_mem = 1; br = 1;
        nxt();
        ctl3("reset", 5'b00000);
        chk("reset.fwd_a", {30'd0, fa3}, 32'd0);
        ctl1("reset", 5'b00000);
        nxt();
        rst = 0;
        idle();

        foreach (tv[i]) begin
            nxt();
            rs1_ex = tv[i].rs1; rs2_ex = tv[i].rs2;
            rd_mem = tv[i].rdm; wren_mem = tv[i].wm; ld_mem = tv[i].lm;
            rd_wb = tv[i].rdw; wren_wb = tv[i].ww; ld_wb = tv[i].lw;
            #1;
            chk($sformatf("fwd_a[%0d]", i), {30'd0, fa3}, {30'd0, tv[i].ea});
            chk($sformatf("fwd_b[%0d]", i), {30'd0, fb3}, {30'd0, tv[i].eb});
            chk($sformatf("fwd_a1[%0d]", i), {30'd0, fa1}, {30'd0, tv[i].ea});
            ctl3($sformatf("fwd_ctl[%0d]", i), 5'b00000);
        end

        nxt(); idle();
        nxt(); load_use();
        ctl3("ld.c1", 5'b11100); ctl1("ld.c1", 5'b11100);
        nxt(); ex_bubble();
        ctl3("ld.c2", 5'b11101); ctl1("ld.c2", 5'b00000);
        nxt();
        ctl3("ld.c3", 5'b11101);
        nxt();
        ctl3("ld.c4", 5'b00000);
`ifdef HAZARD_PERF_EN
        chk("perf_ld.a", pld3, 32'd3);
        chk("perf_fl.a", pfl3, 32'd0);
        chk("perf_ld1.a", pld1, 32'd1);
`endif

        idle();
        rd_ex = 7; wren_ex = 1; ld_ex = 1; rs2_id = 7; use2 = 0;
        ctl3("unused", 5'b00000); ctl1("unused", 5'b00000);
        rd_ex = 0; rs1_id = 0; use1 = 1;
        ctl3("rd0", 5'b00000); ctl1("rd0", 5'b00000);

        nxt(); idle();
        rd_wb = 3; wren_wb = 1; rs1_id = 3; use1 = 1;
        ctl3("rf.c1", 5'b11100); ctl1("rf.c1", 5'b00000);
        nxt();
        ctl3("rf.c2", 5'b00001);
        idle();
        nxt();
        ctl3("rf.c3", 5'b00000);

        nxt(); load_use();
        ctl3("br.c1", 5'b11100);
        nxt(); ex_bubble(); br = 1;
        ctl3("br.c2", 5'b00111); ctl1("br.c2", 5'b00110);
        nxt(); br = 0;
        ctl3("br.c3", 5'b00000);
`ifdef HAZARD_PERF_EN
        chk("perf_ld.b", pld3, 32'd4);
        chk("perf_fl.b", pfl3, 32'd1);
        chk("perf_rf.b", prf3, 32'd1);
`endif

        nxt(); load_use();
        ctl3("rs.c1", 5'b11100);
        nxt(); ex_bubble();
        ctl3("rs.c2", 5'b11101);
        rst = 1;
        ctl3("rs.in", 5'b00000);
        nxt(); rst = 0;
        ctl3("rs.after", 5'b00000);
`ifdef HAZARD_PERF_EN
        chk("perf_ld.clr", pld3, 32'd0);
`endif
        nxt();
        ctl3("rs.after2", 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
